// File: rtl/priority_scanner_pkg.sv
// priority_scanner_pkg: shared types and width helpers for the priority scanner.
// Optional feature macro: PSCAN_COUNT_EN (adds the out_count popcount output).
package priority_scanner_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Index width for a WIDTH-bit vector, never narrower than one bit.
    function automatic int idx_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Width able to hold a popcount of 0..w inclusive.
    function automatic int count_width(input int w);
        return idx_width(w) + 1;
    endfunction

endpackage

// File: rtl/priority_scanner_if.sv
// priority_scanner_if: input vector handshake plus output index beat channel.
// master = vector producer / beat consumer side, slave = the scanner itself.
// Optional feature macro: PSCAN_COUNT_EN (adds out_count to the beat channel).
interface priority_scanner_if
    import priority_scanner_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = idx_width(WIDTH)
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_none;
    logic             out_last;
`ifdef PSCAN_COUNT_EN
    logic [IDX_W:0]   out_count;
`endif

`ifdef PSCAN_COUNT_EN
    modport master (
        output in_valid, in_vec, abort, out_ready,
        input  in_ready, out_valid, out_idx, out_none, out_last, out_count
    );
    modport slave (
        input  in_valid, in_vec, abort, out_ready,
        output in_ready, out_valid, out_idx, out_none, out_last, out_count
    );
`else
    modport master (
        output in_valid, in_vec, abort, out_ready,
        input  in_ready, out_valid, out_idx, out_none, out_last
    );
    modport slave (
        input  in_valid, in_vec, abort, out_ready,
        output in_ready, out_valid, out_idx, out_none, out_last
    );
`endif

endinterface

// File: rtl/priority_scanner_penc_core.sv
// penc_core: combinational priority encoder with any-set and exactly-one-set flags.
module penc_core #(
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = 1,
    parameter int IDX_W     = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             one
);

    // Later loop iterations win, so scan order decides which end has priority.
    always_comb begin
        idx = '0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

    assign any = |vec;
    assign one = any && ((vec & (vec - 1'b1)) == '0);

endmodule

// File: rtl/priority_scanner.sv
// priority_scanner: captures a request vector and emits one index beat per set bit,
// in priority order, with a single flagged beat for an all-zero vector.
// Optional feature macro: PSCAN_COUNT_EN (registers the popcount onto out_count).
module priority_scanner
    import priority_scanner_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = 1,
    parameter int IDX_W     = idx_width(WIDTH)
) (
    input logic              clk,
    input logic              rst,
    priority_scanner_if.slave bus
);

    state_t           state, state_nx;
    logic [WIDTH-1:0] work, work_nx;
    logic             zero_flag, zero_nx;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_one;
    logic             scan;
    logic             last;
    logic             beat;
    logic             accept;
    logic [WIDTH-1:0] clear_mask;

    penc_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_penc (
        .vec (work),
        .idx (enc_idx),
        .any (enc_any),
        .one (enc_one)
    );

    assign scan       = (state == SCAN);
    assign last       = scan & (enc_one | zero_flag);
    assign beat       = scan & bus.out_ready;
    assign bus.in_ready = !rst & !bus.abort & (!scan | (last & bus.out_ready));
    assign accept     = bus.in_valid & bus.in_ready;
    assign clear_mask = WIDTH'(1) << enc_idx;

    assign bus.out_valid = scan;
    assign bus.out_idx   = (scan & enc_any) ? enc_idx : '0;
    assign bus.out_none  = scan & zero_flag;
    assign bus.out_last  = last;

    // Next-state logic: load on accept, retire one bit per beat, reload on the last beat.
    always_comb begin
        state_nx = state;
        work_nx  = work;
        zero_nx  = zero_flag;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = SCAN;
                    work_nx  = bus.in_vec;
                    zero_nx  = (bus.in_vec == '0);
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                    work_nx  = '0;
                    zero_nx  = 1'b0;
                end else if (beat) begin
                    work_nx = work & ~clear_mask;
                    if (last) begin
                        if (accept) begin
                            work_nx = bus.in_vec;
                            zero_nx = (bus.in_vec == '0);
                        end else begin
                            state_nx = IDLE;
                            zero_nx  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                work_nx  = '0;
                zero_nx  = 1'b0;
            end
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_nx;
            work      <= work_nx;
            zero_flag <= zero_nx;
        end
    end

`ifdef PSCAN_COUNT_EN
    logic [IDX_W:0] count_q;

    // Popcount is captured once per vector and held for all of its beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= (IDX_W + 1)'($countones(bus.in_vec));
        end
    end

    assign bus.out_count = scan ? count_q : '0;
`endif

endmodule

// File: doc/priority_scanner.md
# priority_scanner

Parametrised, sequential successor to the combinational 16-bit priority encoder. It captures a WIDTH-bit request vector over a valid/ready input handshake. It then emits the index of every set bit, one per output beat, in priority order, clearing each bit after it is consumed. An all-zero vector yields one flagged "none" beat. The block sits between a request/interrupt-style bit-vector producer and a consumer that services one index at a time.

## Interface
Parameters:
- WIDTH, 16, request vector width; must be ≥ 2, need not be a power of two
- MSB_FIRST, 1, 1 = highest set index first; 0 = lowest first
- IDX_W, $clog2(WIDTH), index width (derived; do not override)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_vec presented
- in_ready  out  1  block can accept a vector
- in_vec  in  WIDTH  request vector
- abort  in  1  discard rest of the current vector
- out_valid  out  1  beat presented
- out_ready  in  1  consumer accepts beat
- out_idx  out  IDX_W  index of current highest-priority set bit; 0 when out_none
- out_none  out  1  captured vector was all zeros
- out_last  out  1  final beat of this vector
- out_count  out  IDX_W+1  popcount of captured vector (only with PSCAN_COUNT_EN)

## Operation
- Two states, IDLE and SCAN. Working register `work` is WIDTH bits.
- IDLE: out_valid=0. An accept (in_valid & in_ready) loads `work`←in_vec, sets a zero flag if in_vec==0, and moves to SCAN.
- SCAN: out_valid=1. out_idx is the priority-encode of `work`, MSB- or LSB-first per MSB_FIRST. out_last=1 when `work` has exactly one set bit or the zero flag is set.
- Beat transfer (out_valid & out_ready): clear bit out_idx in `work`. If out_last, go to IDLE, or reload directly if a new accept occurs in the same cycle.
- in_ready = !rst & !abort & (IDLE | (SCAN & out_last & out_ready)). This gives zero-bubble back-to-back vectors. The path out_ready→in_ready is combinational by design.
- Zero vector: exactly one beat with out_none=1, out_idx=0, out_last=1.
- abort in SCAN: next state IDLE and `work` cleared. Any beat handshaking in that same cycle counts as consumed. No accept is possible in that cycle. abort in IDLE is ignored.
- Outputs out_idx/out_none/out_last/out_count are stable while out_valid & !out_ready.

## Timing
- Reset (async assert, sync release) values:
  - state=IDLE, work=0, out_valid=0, out_idx=0, out_none=0, out_last=0, out_count=0.
  - in_ready=0 while rst is high and 1 in the first cycle after release.
- Latency: a vector accepted at edge N gives its first beat valid in cycle N+1, i.e. after edge N.
- Throughput: a vector with k set bits occupies k cycles (1 cycle if zero) with out_ready held high. The next vector's first beat follows with no gap.
- Reset asserted mid-scan: outputs return to reset values immediately. The remaining bits are lost.
- Encoder is combinational from `work`. It is the critical path for large WIDTH.

## Configuration
- PSCAN_COUNT_EN defined: out_count is present. It holds the popcount of the captured vector, is registered at accept, and is constant for all beats of that vector. It equals 0 for a zero vector.
- Macro absent: out_count port and its popcount logic do not exist. All other behaviour is identical.

## Structure
- Package priority_scanner_pkg holds:
  - the state typedef (IDLE, SCAN)
  - a function computing IDX_W-safe widths
- Sub-module penc_core: purely combinational, parametrised WIDTH/MSB_FIRST. It outputs index, any-set, and exactly-one-set. It is instantiated once on `work`.

## Test plan
Cases 1–5 use WIDTH=16, MSB_FIRST=1.
1. in_vec=16'h8001, out_ready=1 → beats idx=15 last=0, then idx=0 last=1; in_ready high in the last beat's cycle.
2. in_vec=16'h0000 → single beat out_none=1, idx=0, last=1; next cycle IDLE.
3. in_vec=16'h0030, out_ready low for 3 cycles → idx=5 held stable 3 cycles; then beats 5, 4.
4. in_valid held with 16'h0004 then 16'h0100 → idx=2 (last) then idx=8 on the next consecutive cycle; no bubble.
5. Two interrupted 16'hFFFF scans:
   - abort after the first beat → out_valid=0 next cycle, in_ready=1.
   - rst pulse mid-scan → all outputs at reset values immediately.
6. MSB_FIRST=0, PSCAN_COUNT_EN defined, in_vec=16'h0300 → beats idx=8 then idx=9; out_count=2 on both beats.
